// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the block data memory
//               responder: block width, FSM state encoding, default access
//               latency and latency-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Width of one cache block exchanged with the data cache.
  localparam int BLOCK_W = 128;

  // Default number of BUSY cycles per access (legal range 1..255).
  localparam int DEFAULT_LATENCY = 5;

  // Counter width: large enough for LATENCY-1 at the top of the legal range.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Block RAM of 2**DEPTH_LOG2 x BLOCK_W words. Synchronous
//               write, synchronous (registered) read, and a synchronous
//               reset that clears every block and the read register.
// Ports       : clock    - single clock, all updates on posedge
//               reset    - synchronous active-high clear
//               wr_en    - store wr_data at index this edge
//               rd_en    - load rd_data from index this edge
//               index    - block index
//               wr_data  - block to store
//               rd_data  - registered read block, held between reads
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [BLOCK_W-1:0]    wr_data,
  output logic [BLOCK_W-1:0]    rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [BLOCK_W-1:0] mem [DEPTH];

  // Reset takes priority, so a write presented on a reset edge is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[index] <= wr_data;
      end
      if (rd_en) begin
        rd_data <= mem[index];
      end
    end
  end

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_block_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_block_responder
// Description : Memory-side responder for data-cache block misses and
//               write-backs. Accepts one block read or write at a time,
//               holds busywait for LATENCY BUSY cycles, then commits the
//               write or presents the read block during a one-cycle DONE.
// Ports       : clock     - single clock, all state changes on posedge
//               reset     - synchronous active-high reset
//               read      - block read request (level)
//               write     - block write request (level, wins over read)
//               address   - block address; only low DEPTH_LOG2 bits used
//               writedata - block to store
//               readdata  - registered read block, held until next read
//               busywait  - responder busy, requester must wait
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_block_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  address,
  input  logic [BLOCK_W-1:0] writedata,
  output logic [BLOCK_W-1:0] readdata,
  output logic               busywait
);

  dmem_state_t           state;
  dmem_state_t           state_next;
  logic [CNT_W-1:0]      cnt;
  logic                  op_write;
  logic [DEPTH_LOG2-1:0] idx;
  logic [BLOCK_W-1:0]    wdata_cap;
  logic                  access;
  logic                  busy;
  logic                  request;

  assign request = read | write;

  // Upper address bits alias onto the same blocks and are intentionally
  // left unused.
  if (ADDR_W > DEPTH_LOG2) begin : g_upper_addr
    logic unused_upper_addr;
    assign unused_upper_addr = ^address[ADDR_W-1:DEPTH_LOG2];
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        // Combinational so the requester stalls in the very cycle it asks.
        busy = request;
        if (request) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == '0) begin
          access     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (reset) begin
      busy = 1'b0;
    end
  end

  assign busywait = busy;

  // --------------------------------------------------------------------------
  // State, capture registers and latency counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      idx       <= '0;
      wdata_cap <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (request) begin
            // Write wins when both requests are raised together.
            op_write  <= write;
            idx       <= address[DEPTH_LOG2-1:0];
            wdata_cap <= writedata;
            cnt       <= CNT_W'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (access & op_write),
    .rd_en   (access & ~op_write),
    .index   (idx),
    .wr_data (wdata_cap),
    .rd_data (readdata)
  );

endmodule : dmem_block_responder
`default_nettype wire
